// File: rtl/sb_dcache_arbiter_if.sv
// Request/response bundle between the store buffer, the load pipeline and the dcache port.
// The master modport is the arbiter side and the slave modport is the environment side.
interface sb_dcache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  flush_i;
  logic                  sb_valid_i;
  logic                  sb_ready_o;
  logic [ADDR_W-1:0]     sb_addr_i;
  logic [DATA_W-1:0]     sb_data_i;
  logic [DATA_W/8-1:0]   sb_strb_i;
  logic                  ld_req_valid_i;
  logic                  ld_req_ready_o;
  logic [ADDR_W-1:0]     ld_addr_i;
  logic                  ld_resp_valid_o;
  logic                  ld_resp_miss_o;
  logic [DATA_W-1:0]     ld_resp_data_o;
  logic                  dc_req_valid_o;
  logic                  dc_req_ready_i;
  logic                  dc_req_we_o;
  logic [ADDR_W-1:0]     dc_req_addr_o;
  logic [DATA_W-1:0]     dc_req_wdata_o;
  logic [DATA_W/8-1:0]   dc_req_wstrb_o;
  logic                  dc_resp_valid_i;
  logic                  dc_resp_miss_i;
  logic [DATA_W-1:0]     dc_resp_data_i;
  logic                  refill_done_i;

  modport master (
    input  flush_i, sb_valid_i, sb_addr_i, sb_data_i, sb_strb_i,
    input  ld_req_valid_i, ld_addr_i,
    input  dc_req_ready_i, dc_resp_valid_i, dc_resp_miss_i, dc_resp_data_i, refill_done_i,
    output sb_ready_o, ld_req_ready_o, ld_resp_valid_o, ld_resp_miss_o, ld_resp_data_o,
    output dc_req_valid_o, dc_req_we_o, dc_req_addr_o, dc_req_wdata_o, dc_req_wstrb_o
  );

  modport slave (
    output flush_i, sb_valid_i, sb_addr_i, sb_data_i, sb_strb_i,
    output ld_req_valid_i, ld_addr_i,
    output dc_req_ready_i, dc_resp_valid_i, dc_resp_miss_i, dc_resp_data_i, refill_done_i,
    input  sb_ready_o, ld_req_ready_o, ld_resp_valid_o, ld_resp_miss_o, ld_resp_data_o,
    input  dc_req_valid_o, dc_req_we_o, dc_req_addr_o, dc_req_wdata_o, dc_req_wstrb_o
  );
endinterface

// File: rtl/sb_dcache_arbiter.sv
// Arbitrates the single dcache request port between loads and store-buffer drains,
// with load priority bounded by a starvation counter and store miss replay after refill.
module sb_dcache_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
  input  logic                clk,
  input  logic                rst,
  sb_dcache_arbiter_if.master bus
);

  localparam int              STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT, ST_REFILL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_killed;
  logic               r_st_hold;
  logic               r_refilled;
  logic [ADDR_W-1:0]  r_st_addr;
  logic [DATA_W-1:0]  r_st_data;
  logic [STRB_W-1:0]  r_st_strb;

  logic w_st_sel;
  logic w_ld_sel;
  logic w_reissue;
  logic w_st_acc;
  logic w_ld_acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIM) ? LIM : v + CNT_W'(1);
  endfunction

  // A store that was presented but not yet taken keeps the port (r_st_hold).
  assign w_st_sel  = (r_state == IDLE) & bus.sb_valid_i &
                     (r_st_hold | ~bus.ld_req_valid_i | bus.flush_i | (r_starve_cnt == LIM));
  assign w_ld_sel  = (r_state == IDLE) & ~w_st_sel & bus.ld_req_valid_i & ~bus.flush_i;
  assign w_reissue = (r_state == ST_REFILL) & r_refilled;
  assign w_st_acc  = (w_st_sel | w_reissue) & bus.dc_req_ready_i;
  assign w_ld_acc  = w_ld_sel & bus.dc_req_ready_i;

  always_comb begin
    w_state_nxt         = r_state;
    bus.dc_req_valid_o  = 1'b0;
    bus.dc_req_we_o     = 1'b0;
    bus.dc_req_addr_o   = '0;
    bus.dc_req_wdata_o  = '0;
    bus.dc_req_wstrb_o  = '0;
    bus.ld_req_ready_o  = 1'b0;
    bus.ld_resp_valid_o = 1'b0;
    bus.ld_resp_miss_o  = 1'b0;
    bus.ld_resp_data_o  = '0;
    bus.sb_ready_o      = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_st_sel) begin
            bus.dc_req_valid_o = 1'b1;
            bus.dc_req_we_o    = 1'b1;
            bus.dc_req_addr_o  = bus.sb_addr_i;
            bus.dc_req_wdata_o = bus.sb_data_i;
            bus.dc_req_wstrb_o = bus.sb_strb_i;
            if (bus.dc_req_ready_i) w_state_nxt = ST_WAIT;
          end else if (w_ld_sel) begin
            bus.dc_req_valid_o = 1'b1;
            bus.dc_req_addr_o  = bus.ld_addr_i;
            bus.ld_req_ready_o = bus.dc_req_ready_i;
            if (bus.dc_req_ready_i) w_state_nxt = LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (bus.dc_resp_valid_i) begin
            w_state_nxt         = IDLE;
            bus.ld_resp_valid_o = ~(r_killed | bus.flush_i);
            if (bus.ld_resp_valid_o) begin
              bus.ld_resp_miss_o = bus.dc_resp_miss_i;
              bus.ld_resp_data_o = bus.dc_resp_data_i;
            end
          end
        end
        ST_WAIT: begin
          if (bus.dc_resp_valid_i) begin
            if (bus.dc_resp_miss_i) begin
              w_state_nxt = ST_REFILL;
            end else begin
              bus.sb_ready_o = bus.sb_valid_i;
              w_state_nxt    = IDLE;
            end
          end
        end
        ST_REFILL: begin
          if (r_refilled) begin
            bus.dc_req_valid_o = 1'b1;
            bus.dc_req_we_o    = 1'b1;
            bus.dc_req_addr_o  = r_st_addr;
            bus.dc_req_wdata_o = r_st_data;
            bus.dc_req_wstrb_o = r_st_strb;
            if (bus.dc_req_ready_i) w_state_nxt = ST_WAIT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_killed     <= 1'b0;
      r_st_hold    <= 1'b0;
      r_refilled   <= 1'b0;
      r_st_addr    <= '0;
      r_st_data    <= '0;
      r_st_strb    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_st_hold <= w_st_sel & ~bus.dc_req_ready_i;

      if (!bus.sb_valid_i || w_st_acc) r_starve_cnt <= '0;
      else if (w_ld_acc)               r_starve_cnt <= sat_inc(r_starve_cnt);

      // A flush anywhere between accept and response suppresses that load's reply.
      if (r_state == LD_WAIT && w_state_nxt == IDLE)                r_killed <= 1'b0;
      else if (bus.flush_i && (r_state == LD_WAIT || w_ld_acc))     r_killed <= 1'b1;

      if (r_state != ST_REFILL)     r_refilled <= 1'b0;
      else if (w_st_acc)            r_refilled <= 1'b0;
      else if (bus.refill_done_i)   r_refilled <= 1'b1;

      if (w_st_sel && bus.dc_req_ready_i) begin
        r_st_addr <= bus.sb_addr_i;
        r_st_data <= bus.sb_data_i;
        r_st_strb <= bus.sb_strb_i;
      end
    end
  end

endmodule

// File: tb/tb_sb_dcache_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts every dcache grant,
// load reply and store-buffer pop; a separate monitor matches them against the DUT.
module tb_sb_dcache_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int STARVE_LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sb_dcache_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sb_dcache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; logic [STRB_W-1:0] s;} st_t;
  typedef struct {int cyc; logic we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; logic [STRB_W-1:0] s;} req_t;
  typedef struct {int cyc; logic miss; logic [DATA_W-1:0] d;} ldr_t;

  st_t  sb_q[$];
  req_t exp_req[$];
  ldr_t exp_ldr[$];
  int   exp_ldacc[$];
  int   exp_pop[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: 0 idle, 1 load outstanding, 2 store outstanding, 3 awaiting refill, 4 refilled
  int   m_busy = 0, m_wait = 0, m_ref = 0, m_consec = 0;
  bit   m_present = 0, m_killed = 0, m_miss = 0;
  logic [DATA_W-1:0] m_data;
  st_t  m_held;

  int p_ld, p_fl, p_rdy, p_st, p_miss, p_spref, rmin, rmax;
  bit spur_resp = 0;

  function automatic bit pct(int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic plan();
    m_wait = int'($urandom_range(rmin, rmax));
    m_miss = pct(p_miss);
    m_data = $urandom;
  endtask

  task automatic apply(bit fl, bit sbv, st_t h, bit lv, logic [ADDR_W-1:0] la, bit rdy,
                       bit resp, bit rmiss, logic [DATA_W-1:0] rd, bit refp);
    bus.flush_i         = fl;
    bus.sb_valid_i      = sbv;
    bus.sb_addr_i       = h.a;
    bus.sb_data_i       = h.d;
    bus.sb_strb_i       = h.s;
    bus.ld_req_valid_i  = lv;
    bus.ld_addr_i       = la;
    bus.dc_req_ready_i  = rdy;
    bus.dc_resp_valid_i = resp;
    bus.dc_resp_miss_i  = rmiss;
    bus.dc_resp_data_i  = rd;
    bus.refill_done_i   = refp;
  endtask

  task automatic head(output bit sbv, output st_t h);
    sbv = (sb_q.size() != 0);
    if (sbv) h = sb_q[0];
    else begin h.a = '0; h.d = '0; h.s = '0; end
  endtask

  task automatic do_reset(int n);
    st_t h; bit sbv;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; cyc++;
      rst = 1'b1;
      head(sbv, h);
      apply(1'b0, sbv, h, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, $urandom, 1'b1);
      @(negedge clk);
      chk("reset_outputs",
          {bus.dc_req_valid_o, bus.sb_ready_o, bus.ld_req_ready_o, bus.ld_resp_valid_o,
           bus.ld_resp_miss_o, bus.ld_resp_data_o, bus.dc_req_we_o, bus.dc_req_addr_o,
           bus.dc_req_wdata_o, bus.dc_req_wstrb_o}, 128'd0);
    end
    m_busy = 0; m_consec = 0; m_present = 0; m_killed = 0;
  endtask

  task automatic step();
    st_t h; bit sbv, fl, lv, rdy, resp, rmiss, refp, st_sel, ld_sel;
    logic [ADDR_W-1:0] la; logic [DATA_W-1:0] rd;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    if (sb_q.size() < 3 && pct(p_st)) begin
      h.a = $urandom; h.d = $urandom; h.s = STRB_W'($urandom_range(1, (1 << STRB_W) - 1));
      sb_q.push_back(h);
    end
    head(sbv, h);
    fl = pct(p_fl); lv = pct(p_ld); rdy = pct(p_rdy);
    la = $urandom; rd = $urandom; resp = 0; rmiss = 0; refp = 0;
    if (m_busy == 1 || m_busy == 2) begin
      m_wait--;
      if (m_wait == 0) begin resp = 1; rmiss = m_miss; rd = m_data; end
    end else if (m_busy == 0 && spur_resp) resp = 1;
    if (m_busy == 3) begin
      m_ref--;
      if (m_ref == 0) refp = 1;
    end else if (m_busy != 4 && pct(p_spref)) refp = 1;
    apply(fl, sbv, h, lv, la, rdy, resp, rmiss, rd, refp);

    case (m_busy)
      0: begin
        st_sel = sbv && (m_present || !lv || fl || m_consec == STARVE_LIM);
        ld_sel = !st_sel && lv && !fl;
        m_present = st_sel && !rdy;
        if (st_sel && rdy) begin
          exp_req.push_back('{cyc, 1'b1, h.a, h.d, h.s});
          m_held = h; m_busy = 2; m_consec = 0; plan();
        end else if (ld_sel && rdy) begin
          exp_req.push_back('{cyc, 1'b0, la, '0, '0});
          exp_ldacc.push_back(cyc);
          m_busy = 1; m_killed = fl; plan();
          if (sbv) m_consec = (m_consec < STARVE_LIM) ? m_consec + 1 : STARVE_LIM;
        end
      end
      1: begin
        if (fl) m_killed = 1;
        if (resp) begin
          if (!m_killed) exp_ldr.push_back('{cyc, rmiss, rd});
          m_busy = 0; m_killed = 0;
        end
      end
      2: if (resp) begin
        if (!rmiss) begin
          exp_pop.push_back(cyc);
          void'(sb_q.pop_front());
          m_busy = 0;
        end else begin
          m_busy = 3; m_ref = int'($urandom_range(1, 6));
        end
      end
      3: if (refp) m_busy = 4;
      4: if (rdy) begin
        exp_req.push_back('{cyc, 1'b1, m_held.a, m_held.d, m_held.s});
        m_busy = 2; m_consec = 0; plan();
      end
      default: m_busy = 0;
    endcase
    if (!sbv) m_consec = 0;
  endtask

  initial begin : monitor
    req_t e; ldr_t l; int t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.dc_req_valid_o && bus.dc_req_ready_i) begin
          if (exp_req.size() == 0) chk("dc_req_unexpected", exp_req.size(), 1);
          else begin
            e = exp_req.pop_front();
            chk("dc_req", {cyc, bus.dc_req_we_o, bus.dc_req_addr_o, bus.dc_req_wdata_o, bus.dc_req_wstrb_o},
                {e.cyc, e.we, e.a, e.d, e.s});
          end
        end
        if (bus.ld_req_ready_o) begin
          if (exp_ldacc.size() == 0) chk("ld_accept_unexpected", exp_ldacc.size(), 1);
          else begin t = exp_ldacc.pop_front(); chk("ld_accept_cycle", cyc, t); end
        end
        if (bus.ld_resp_valid_o) begin
          if (exp_ldr.size() == 0) chk("ld_resp_unexpected", exp_ldr.size(), 1);
          else begin
            l = exp_ldr.pop_front();
            chk("ld_resp", {cyc, bus.ld_resp_miss_o, bus.ld_resp_data_o}, {l.cyc, l.miss, l.d});
          end
        end
        if (bus.sb_ready_o) begin
          if (exp_pop.size() == 0) chk("sb_pop_unexpected", exp_pop.size(), 1);
          else begin t = exp_pop.pop_front(); chk("sb_pop_cycle", cyc, t); end
        end
      end
    end
  end

  initial begin : driver
    st_t s0;
    p_ld = 0; p_fl = 0; p_rdy = 100; p_st = 0; p_miss = 0; p_spref = 0; rmin = 3; rmax = 3;
    do_reset(3);

    // Store hit after reset abandoned an in-flight store
    s0.a = 32'h100; s0.d = 32'hDEADBEEF; s0.s = 4'hF;
    sb_q.push_back(s0);
    step();
    step();
    do_reset(2);
    spur_resp = 1; step(); spur_resp = 0;
    repeat (8) step();

    // Store miss with loads waiting during refill
    rmin = 2; rmax = 2; p_miss = 100;
    sb_q.push_back(s0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (m_busy >= 2) p_ld = 100;
      if (m_busy == 3) p_miss = 0;
    end

    // Starvation: loads always requested, stores always pending
    p_ld = 100; p_st = 100; p_fl = 0; p_rdy = 100; rmin = 1; rmax = 1; p_miss = 0;
    repeat (60) step();

    // Mixed random traffic with flushes, stalls, misses and stray refill pulses
    p_ld = 60; p_st = 20; p_fl = 12; p_rdy = 70; rmin = 1; rmax = 4; p_miss = 30; p_spref = 5;
    repeat (3000) step();

    p_ld = 0; p_st = 0; p_fl = 0; p_rdy = 100; p_miss = 0; p_spref = 0;
    repeat (120) step();
    @(negedge clk); #1;

    chk("pending_dc_req", exp_req.size(), 0);
    chk("pending_ld_accept", exp_ldacc.size(), 0);
    chk("pending_ld_resp", exp_ldr.size(), 0);
    chk("pending_sb_pop", exp_pop.size(), 0);
    chk("store_buffer_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
